// File: rtl/datapath_seq.sv
// datapath_seq: microsequencer that steps the 16-bit datapath through
// read-operand / compute / write-back cycles for one instruction at a time.
// Optional build macro DATAPATH_SEQ_B2B_EN: accept the next instruction while
// in DONE (back-to-back issue). Without it, ready is only high in IDLE.
// Control outputs are registered from the next state and next latched
// instruction, so they are Moore with respect to the visible state and drop
// asynchronously on reset.
module datapath_seq #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       instr,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] datapath_in,
  output logic              vsel,
  output logic              write,
  output logic [2:0]        writenum,
  output logic [2:0]        readnum,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_WR_IMM  = 3'd2;
  localparam logic [2:0] S_GET_A   = 3'd3;
  localparam logic [2:0] S_GET_B   = 3'd4;
  localparam logic [2:0] S_COMPUTE = 3'd5;
  localparam logic [2:0] S_WB      = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [1:0] C_MOVI = 2'd0;
  localparam logic [1:0] C_MOVR = 2'd1;
  localparam logic [1:0] C_ALU  = 2'd2;
  localparam logic [1:0] C_UND  = 2'd3;

`ifdef DATAPATH_SEQ_B2B_EN
  localparam logic B2B = 1'b1;
`else
  localparam logic B2B = 1'b0;
`endif

  // Instruction class from opc/op fields
  function automatic logic [1:0] f_class(input logic [15:0] i);
    logic [1:0] c;
    c = C_UND;
    if (i[15:13] == 3'b110 && i[12:11] == 2'b10)      c = C_MOVI;
    else if (i[15:13] == 3'b110 && i[12:11] == 2'b00) c = C_MOVR;
    else if (i[15:13] == 3'b101)                      c = C_ALU;
    return c;
  endfunction

  logic [2:0]        r_state;
  logic [15:0]       r_instr;
  logic [2:0]        w_nxt_state;
  logic [15:0]       w_nxt_instr;
  logic              w_accept;
  logic [1:0]        w_cls_r;
  logic [1:0]        w_cls_n;
  logic [1:0]        w_op_n;
  logic              w_n_ready, w_n_done, w_n_err, w_n_vsel, w_n_write;
  logic [2:0]        w_n_writenum, w_n_readnum;
  logic              w_n_loada, w_n_loadb, w_n_loadc, w_n_loads, w_n_asel;
  logic [1:0]        w_n_shift, w_n_aluop;
  logic [DATA_W-1:0] w_n_din;

  assign w_cls_r = f_class(r_instr);

  // Next state, instruction latch and next registered control outputs
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_instr  = r_instr;
    w_n_ready    = 1'b0;
    w_n_done     = 1'b0;
    w_n_err      = 1'b0;
    w_n_vsel     = 1'b0;
    w_n_write    = 1'b0;
    w_n_writenum = 3'd0;
    w_n_readnum  = 3'd0;
    w_n_loada    = 1'b0;
    w_n_loadb    = 1'b0;
    w_n_loadc    = 1'b0;
    w_n_loads    = 1'b0;
    w_n_asel     = 1'b0;
    w_n_shift    = 2'd0;
    w_n_aluop    = 2'd0;

    w_accept = start & ((r_state == S_IDLE) | (B2B & (r_state == S_DONE)));
    if (w_accept) w_nxt_instr = instr;

    case (r_state)
      S_IDLE:    if (w_accept) w_nxt_state = S_DECODE;
      S_DECODE: begin
        case (w_cls_r)
          C_MOVI:  w_nxt_state = S_WR_IMM;
          C_MOVR:  w_nxt_state = S_GET_B;
          C_ALU:   w_nxt_state = (r_instr[12:11] == 2'b11) ? S_GET_B : S_GET_A;
          default: w_nxt_state = S_DONE;
        endcase
      end
      S_WR_IMM:  w_nxt_state = S_DONE;
      S_GET_A:   w_nxt_state = S_GET_B;
      S_GET_B:   w_nxt_state = S_COMPUTE;
      S_COMPUTE: w_nxt_state = (w_cls_r == C_ALU && r_instr[12:11] == 2'b01) ? S_DONE : S_WB;
      S_WB:      w_nxt_state = S_DONE;
      default:   w_nxt_state = w_accept ? S_DECODE : S_IDLE;
    endcase

    w_cls_n = f_class(w_nxt_instr);
    w_op_n  = w_nxt_instr[12:11];
    w_n_din = {{EXT_W{w_nxt_instr[IMM_W-1]}}, w_nxt_instr[IMM_W-1:0]};

    case (w_nxt_state)
      S_IDLE:   w_n_ready = 1'b1;
      S_WR_IMM: begin
        w_n_vsel     = 1'b1;
        w_n_write    = 1'b1;
        w_n_writenum = w_nxt_instr[10:8];
      end
      S_GET_A: begin
        w_n_readnum = w_nxt_instr[10:8];
        w_n_loada   = 1'b1;
      end
      S_GET_B: begin
        w_n_readnum = w_nxt_instr[2:0];
        w_n_loadb   = 1'b1;
      end
      S_COMPUTE: begin
        w_n_shift = w_nxt_instr[4:3];
        w_n_loadc = 1'b1;
        w_n_asel  = (w_cls_n == C_MOVR) | ((w_cls_n == C_ALU) & (w_op_n == 2'b11));
        w_n_aluop = (w_cls_n == C_MOVR) ? 2'b00 : w_op_n;
        w_n_loads = (w_cls_n == C_ALU);
      end
      S_WB: begin
        w_n_write    = 1'b1;
        w_n_writenum = w_nxt_instr[7:5];
      end
      S_DONE: begin
        w_n_done  = 1'b1;
        w_n_err   = (w_cls_n == C_UND);
        w_n_ready = B2B;
      end
      default: ;
    endcase
  end

  // State, latched instruction and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_instr     <= 16'd0;
      ready       <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      datapath_in <= '0;
      vsel        <= 1'b0;
      write       <= 1'b0;
      writenum    <= 3'd0;
      readnum     <= 3'd0;
      loada       <= 1'b0;
      loadb       <= 1'b0;
      loadc       <= 1'b0;
      loads       <= 1'b0;
      asel        <= 1'b0;
      bsel        <= 1'b0;
      shift       <= 2'd0;
      ALUop       <= 2'd0;
    end else begin
      r_state     <= w_nxt_state;
      r_instr     <= w_nxt_instr;
      ready       <= w_n_ready;
      done        <= w_n_done;
      err         <= w_n_err;
      datapath_in <= w_n_din;
      vsel        <= w_n_vsel;
      write       <= w_n_write;
      writenum    <= w_n_writenum;
      readnum     <= w_n_readnum;
      loada       <= w_n_loada;
      loadb       <= w_n_loadb;
      loadc       <= w_n_loadc;
      loads       <= w_n_loads;
      asel        <= w_n_asel;
      bsel        <= 1'b0;
      shift       <= w_n_shift;
      ALUop       <= w_n_aluop;
    end
  end

endmodule
